// File: rtl/types_pkg.sv
// Shared geometry and model-buffer transaction types.
package types_pkg;

    localparam int unsigned COORD_W = 16;
    localparam int unsigned SHORT_W = 16;

    typedef logic [SHORT_W-1:0] short_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle_t;

    typedef struct packed {
        logic last;
    } triangle_meta_t;

    typedef struct packed {
        short_t model_index;
        short_t triangle_index;
    } modelbuf_read_t;

    typedef struct packed {
        short_t    model_index;
        short_t    triangle_index;
        triangle_t triangle;
    } modelbuf_write_t;

endpackage

// File: rtl/model_buffer_ram.sv
// Triangle storage: one write port, one synchronous read port, read-before-write, no reset.
module model_buffer_ram
    import types_pkg::*;
#(
    parameter int unsigned DEPTH = 1000,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  triangle_t     wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output triangle_t     rd_data_o
);

    triangle_t mem_q [DEPTH];

    // Read samples the pre-write contents, so a same-address access returns old data.
    always_ff @(posedge clk) begin
        rd_data_o <= mem_q[rd_addr_i];
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/model_buffer.sv
// Per-model triangle store with an in-order, flow-controlled fetch path.
module model_buffer
    import types_pkg::*;
#(
    parameter int unsigned MAX_MODEL_COUNT    = 10,
    parameter int unsigned MAX_TRIANGLE_COUNT = 100
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            write_in_valid,
    output logic            write_in_ready,
    input  modelbuf_write_t write_in_data,
    input  logic            write_in_last,
    input  logic            read_in_valid,
    output logic            read_in_ready,
    input  modelbuf_read_t  read_in_data,
    output logic            read_out_valid,
    input  logic            read_out_ready,
    output triangle_t       read_out_data,
    output triangle_meta_t  read_out_metadata
);

    localparam int unsigned OUT_DEPTH = 3;
    localparam int unsigned DEPTH     = MAX_MODEL_COUNT * MAX_TRIANGLE_COUNT;
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MW        = (MAX_MODEL_COUNT > 1) ? $clog2(MAX_MODEL_COUNT) : 1;
    localparam int unsigned CW        = $clog2(OUT_DEPTH + 1);

    logic            write_ready_q;
    logic            read_ready_q, read_ready_d;
    logic            s1_vld_q;
    logic            s1_last_q;
    triangle_t       q_data_q [OUT_DEPTH];
    triangle_t       q_data_d [OUT_DEPTH];
    logic            q_last_q [OUT_DEPTH];
    logic            q_last_d [OUT_DEPTH];
    logic [CW-1:0]   q_cnt_q, q_cnt_d;
    logic            q_vld_q;
    short_t          count_q [MAX_MODEL_COUNT];

    logic            wr_ok_c;
    logic [AW-1:0]   wr_addr_c;
    logic [AW-1:0]   rd_addr_c;
    logic            rd_model_ok_c;
    short_t          rd_cnt_c;
    logic            rd_hit_c;
    logic            rd_last_c;
    logic            pop_c;
    triangle_t       ram_rdata;

    // Request/write decode against the pre-edge count registers.
    assign wr_ok_c = write_in_valid && write_ready_q
                  && (32'(write_in_data.model_index) < MAX_MODEL_COUNT)
                  && (32'(write_in_data.triangle_index) < MAX_TRIANGLE_COUNT);
    assign wr_addr_c = AW'(32'(write_in_data.model_index) * MAX_TRIANGLE_COUNT
                         + 32'(write_in_data.triangle_index));
    assign rd_addr_c = AW'(32'(read_in_data.model_index) * MAX_TRIANGLE_COUNT
                         + 32'(read_in_data.triangle_index));
    assign rd_model_ok_c = 32'(read_in_data.model_index) < MAX_MODEL_COUNT;
    assign rd_cnt_c  = rd_model_ok_c ? count_q[MW'(read_in_data.model_index)] : '0;
    assign rd_hit_c  = read_in_valid && read_ready_q && rd_model_ok_c
                    && (read_in_data.triangle_index < rd_cnt_c);
    assign rd_last_c = read_in_data.triangle_index == (rd_cnt_c - short_t'(1));
    assign pop_c     = q_vld_q && read_out_ready;

    model_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_ok_c),
        .wr_addr_i (wr_addr_c),
        .wr_data_i (write_in_data.triangle),
        .rd_addr_i (rd_addr_c),
        .rd_data_o (ram_rdata)
    );

    // Output queue: shift on pop, append RAM data behind the surviving entries.
    always_comb begin
        q_data_d = q_data_q;
        q_last_d = q_last_q;
        q_cnt_d  = q_cnt_q;
        if (pop_c) begin
            for (int i = 0; i < int'(OUT_DEPTH) - 1; i++) begin
                q_data_d[i] = q_data_q[i+1];
                q_last_d[i] = q_last_q[i+1];
            end
            q_cnt_d = q_cnt_q - CW'(1);
        end
        if (s1_vld_q) begin
            for (int i = 0; i < int'(OUT_DEPTH); i++) begin
                if (CW'(i) == q_cnt_d) begin
                    q_data_d[i] = ram_rdata;
                    q_last_d[i] = s1_last_q;
                end
            end
            q_cnt_d = q_cnt_d + CW'(1);
        end
        read_ready_d = (32'(rd_hit_c) + 32'(q_cnt_d)) < OUT_DEPTH;
    end

    // Handshake, fetch pipeline and output queue registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            write_ready_q <= 1'b0;
            read_ready_q  <= 1'b0;
            s1_vld_q      <= 1'b0;
            s1_last_q     <= 1'b0;
            q_cnt_q       <= '0;
            q_vld_q       <= 1'b0;
            for (int i = 0; i < int'(OUT_DEPTH); i++) begin
                q_data_q[i] <= '0;
                q_last_q[i] <= 1'b0;
            end
        end else begin
            write_ready_q <= 1'b1;
            read_ready_q  <= read_ready_d;
            s1_vld_q      <= rd_hit_c;
            s1_last_q     <= rd_last_c;
            q_cnt_q       <= q_cnt_d;
            q_vld_q       <= q_cnt_d != '0;
            q_data_q      <= q_data_d;
            q_last_q      <= q_last_d;
        end
    end

    // Per-model triangle counts, set by the final write of a model load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(MAX_MODEL_COUNT); i++) begin
                count_q[i] <= '0;
            end
        end else if (wr_ok_c && write_in_last) begin
            count_q[MW'(write_in_data.model_index)] <= write_in_data.triangle_index + short_t'(1);
        end
    end

    assign write_in_ready         = write_ready_q;
    assign read_in_ready          = read_ready_q;
    assign read_out_valid         = q_vld_q;
    assign read_out_data          = q_data_q[0];
    assign read_out_metadata.last = q_last_q[0];

endmodule

// File: tb/tb_model_buffer.sv
// Scoreboard bench for model_buffer: directed scenarios plus a randomized phase.
module tb_model_buffer;
    import types_pkg::*;

    localparam int MMC = 10;
    localparam int MTC = 100;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            write_in_valid;
    logic            write_in_ready;
    modelbuf_write_t write_in_data;
    logic            write_in_last;
    logic            read_in_valid;
    logic            read_in_ready;
    modelbuf_read_t  read_in_data;
    logic            read_out_valid;
    logic            read_out_ready;
    triangle_t       read_out_data;
    triangle_meta_t  read_out_metadata;

    always #5 clk = ~clk;

    model_buffer #(
        .MAX_MODEL_COUNT    (MMC),
        .MAX_TRIANGLE_COUNT (MTC)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .write_in_valid    (write_in_valid),
        .write_in_ready    (write_in_ready),
        .write_in_data     (write_in_data),
        .write_in_last     (write_in_last),
        .read_in_valid     (read_in_valid),
        .read_in_ready     (read_in_ready),
        .read_in_data      (read_in_data),
        .read_out_valid    (read_out_valid),
        .read_out_ready    (read_out_ready),
        .read_out_data     (read_out_data),
        .read_out_metadata (read_out_metadata)
    );

    typedef struct {
        triangle_t tdat;
        logic      last;
        int        acc_cyc;
    } exp_t;

    exp_t      sb[$];
    int        resp_cyc[$];
    triangle_t ref_mem [MMC][MTC];
    int        ref_cnt [MMC];
    int        cyc = 0;
    int        n_tests = 0;
    int        n_fail = 0;
    int        n_acc = 0;
    int        n_resp = 0;

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_tri(input string name, input triangle_t act, input triangle_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic triangle_t rand_tri();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return triangle_t'(r[143:0]);
    endfunction

    always @(posedge clk) cyc++;

    // Reference model: a request sees the counts and contents as they were before this cycle's write.
    exp_t me;
    int   mm, mt;
    always @(negedge clk) begin
        if (rstn) begin
            if (read_in_valid && read_in_ready) begin
                n_acc++;
                mm = int'(read_in_data.model_index);
                mt = int'(read_in_data.triangle_index);
                if (mm < MMC && mt < ref_cnt[mm]) begin
                    me.tdat    = ref_mem[mm][mt];
                    me.last    = (mt == ref_cnt[mm] - 1);
                    me.acc_cyc = cyc;
                    sb.push_back(me);
                end
            end
            if (write_in_valid && write_in_ready) begin
                mm = int'(write_in_data.model_index);
                mt = int'(write_in_data.triangle_index);
                if (mm < MMC && mt < MTC) begin
                    ref_mem[mm][mt] = write_in_data.triangle;
                    if (write_in_last) ref_cnt[mm] = mt + 1;
                end
            end
        end
    end

    // Monitor: compare every transferred response with the oldest expectation.
    exp_t      oe;
    logic      hold_pending = 1'b0;
    triangle_t hold_data;
    logic      hold_last;
    always @(negedge clk) begin
        if (!rstn) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk_int("hold_valid", int'(read_out_valid), 1);
                chk_tri("hold_data", read_out_data, hold_data);
                chk_int("hold_last", int'(read_out_metadata.last), int'(hold_last));
            end
            hold_pending = read_out_valid && !read_out_ready;
            hold_data    = read_out_data;
            hold_last    = read_out_metadata.last;
            if (read_out_valid && read_out_ready) begin
                n_resp++;
                resp_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    chk_int("unexpected_response", 1, 0);
                end else begin
                    oe = sb.pop_front();
                    chk_tri("resp_data", read_out_data, oe.tdat);
                    chk_int("resp_last", int'(read_out_metadata.last), int'(oe.last));
                    chk_int("resp_latency_min", int'((cyc - oe.acc_cyc) >= 2), 1);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string name);
        int  k;
        bit  done;
        k = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (read_in_ready) done = 1;
            @(posedge clk);
            #1;
            k++;
            if (!done && k > 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: request not accepted within 50 cycles", name);
                done = 1;
            end
        end
        read_in_valid = 1'b0;
    endtask

    task automatic set_read(input int m, input int t);
        read_in_data.model_index    = short_t'(m);
        read_in_data.triangle_index = short_t'(t);
        read_in_valid = 1'b1;
    endtask

    task automatic do_read(input int m, input int t);
        set_read(m, t);
        wait_accept("read_accept");
    endtask

    task automatic set_write(input int m, input int t, input triangle_t d, input bit last);
        write_in_data.model_index    = short_t'(m);
        write_in_data.triangle_index = short_t'(t);
        write_in_data.triangle       = d;
        write_in_last  = last;
        write_in_valid = 1'b1;
    endtask

    task automatic do_write(input int m, input int t, input triangle_t d, input bit last);
        set_write(m, t, d, last);
        @(posedge clk);
        #1;
        write_in_valid = 1'b0;
        write_in_last  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r0;
        bit rfire;
        write_in_valid = 1'b0;
        write_in_last  = 1'b0;
        write_in_data  = '0;
        read_in_valid  = 1'b0;
        read_in_data   = '0;
        read_out_ready = 1'b1;
        for (int i = 0; i < MMC; i++) ref_cnt[i] = 0;

        // Reset values
        #2;
        chk_int("rst_write_ready", int'(write_in_ready), 0);
        chk_int("rst_read_ready", int'(read_in_ready), 0);
        chk_int("rst_out_valid", int'(read_out_valid), 0);
        chk_tri("rst_out_data", read_out_data, '0);
        chk_int("rst_out_last", int'(read_out_metadata.last), 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk_int("post_rst_write_ready", int'(write_in_ready), 1);
        chk_int("post_rst_read_ready", int'(read_in_ready), 1);

        // Give every slot used later defined contents without setting any count
        for (int m = 0; m < MMC; m++)
            for (int t = 0; t < 8; t++)
                do_write(m, t, rand_tri(), 1'b0);

        // Load model 2 and fetch it back-to-back
        for (int t = 0; t < 4; t++) do_write(2, t, rand_tri(), t == 3);
        idle(1);
        resp_cyc.delete();
        a0 = cyc;
        for (int t = 0; t < 4; t++) do_read(2, t);
        idle(6);
        chk_int("b2b_resp_count", resp_cyc.size(), 4);
        if (resp_cyc.size() > 0) chk_int("b2b_first_latency", resp_cyc[0] - a0, 2);
        for (int i = 1; i < resp_cyc.size(); i++)
            chk_int("b2b_consecutive", resp_cyc[i] - resp_cyc[i-1], 1);

        // Invalid requests: accepted at once, no response
        r0 = n_resp;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_read(2, 4);
                1: set_read(9, 0);
                default: set_read(12, 0);
            endcase
            @(negedge clk);
            chk_int("invalid_req_ready", int'(read_in_ready), 1);
            @(posedge clk);
            #1;
            read_in_valid = 1'b0;
        end
        idle(5);
        chk_int("invalid_no_resp", n_resp - r0, 0);
        chk_int("invalid_ready_after", int'(read_in_ready), 1);

        // Backpressure: three accepted, fourth blocked until drain
        read_out_ready = 1'b0;
        r0 = n_resp;
        a0 = n_acc;
        for (int t = 0; t < 3; t++) do_read(2, t);
        set_read(2, 3);
        repeat (4) begin
            @(negedge clk);
            chk_int("bp_read_ready_low", int'(read_in_ready), 0);
        end
        chk_int("bp_accepted", n_acc - a0, 3);
        read_out_ready = 1'b1;
        wait_accept("bp_fourth");
        idle(6);
        chk_int("bp_resp_count", n_resp - r0, 4);

        // Same-cycle write and read of 2/1: old data first, then new
        r0 = n_resp;
        set_write(2, 1, rand_tri(), 1'b0);
        set_read(2, 1);
        @(negedge clk);
        chk_int("rw_same_ready", int'(read_in_ready), 1);
        @(posedge clk);
        #1;
        write_in_valid = 1'b0;
        read_in_valid  = 1'b0;
        do_read(2, 1);
        idle(6);
        chk_int("rw_resp_count", n_resp - r0, 2);

        // Reload model 2 with two triangles
        r0 = n_resp;
        do_write(2, 0, rand_tri(), 1'b0);
        do_write(2, 1, rand_tri(), 1'b1);
        idle(1);
        do_read(2, 1);
        do_read(2, 2);
        idle(6);
        chk_int("reload_resp_count", n_resp - r0, 1);

        // Reset with two responses pending
        read_out_ready = 1'b0;
        do_read(2, 0);
        do_read(2, 1);
        idle(2);
        chk_int("pre_rst_valid", int'(read_out_valid), 1);
        rstn = 1'b0;
        sb.delete();
        for (int i = 0; i < MMC; i++) ref_cnt[i] = 0;
        #1;
        chk_int("midrst_out_valid", int'(read_out_valid), 0);
        chk_int("midrst_read_ready", int'(read_in_ready), 0);
        idle(2);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk_int("rel_write_ready", int'(write_in_ready), 1);
        chk_int("rel_read_ready", int'(read_in_ready), 1);
        read_out_ready = 1'b1;
        r0 = n_resp;
        do_read(2, 0);
        idle(5);
        chk_int("after_rst_no_resp", n_resp - r0, 0);

        // Randomized traffic
        rfire = 0;
        repeat (1500) begin
            write_in_valid = ($urandom_range(0, 1) == 1);
            write_in_data.model_index    = short_t'($urandom_range(0, 11));
            write_in_data.triangle_index = short_t'(($urandom_range(0, 9) == 0) ?
                                                    $urandom_range(100, 103) : $urandom_range(0, 7));
            write_in_data.triangle       = rand_tri();
            write_in_last  = ($urandom_range(0, 3) == 0);
            if (!read_in_valid || rfire) begin
                read_in_valid = ($urandom_range(0, 3) != 0);
                read_in_data.model_index    = short_t'($urandom_range(0, 11));
                read_in_data.triangle_index = short_t'($urandom_range(0, 9));
            end
            read_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            rfire = read_in_valid && read_in_ready;
            @(posedge clk);
            #1;
        end
        write_in_valid = 1'b0;
        write_in_last  = 1'b0;
        read_in_valid  = 1'b0;
        read_out_ready = 1'b1;

        // Drain
        for (int k = 0; k < 100 && sb.size() != 0; k++) idle(1);
        idle(3);
        chk_int("drain_scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
